pwm_ramp_ctrl: RTL and testbench

Sequencer that configures one pwm channel and moves its duty value from a start value to a target value in fixed steps, at a programmable number of PWM periods per step (soft-start / soft-stop). It sits between the host command logic and a single pwm instance, and owns that instance's enDC, writePeriod and data inputs. It observes the instance's outEventCnt to stay aligned with period boundaries.

---
 rtl/pwm_ramp_ctrl.sv | 147 ++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer for one pwm channel: loads the period, then
// walks the duty value from a start value to a target in fixed steps.
module pwm_ramp_ctrl (
  input  logic        refClock,
  input  logic        resetN,
  input  logic        cmdStart,
  input  logic        cmdStop,
  input  logic [15:0] cfgPeriod,
  input  logic [15:0] cfgStartDuty,
  input  logic [15:0] cfgTargetDuty,
  input  logic [15:0] cfgStep,
  input  logic [7:0]  cfgHold,
  input  logic        pwmEvent,
  output logic        pwmEnDC,
  output logic        pwmWritePeriod,
  output logic [15:0] pwmData,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, LOAD, GAP, RAMP, FINISH} stateT;

  stateT       state;
  logic [15:0] curDuty;
  logic [15:0] periodReg;
  logic [15:0] effTarget;
  logic [15:0] stepReg;
  logic [7:0]  effHold;
  logic [7:0]  holdCnt;
  logic [1:0]  loadCnt;
  logic        stopPending;

  logic [15:0] startClamped;
  logic [15:0] targetClamped;
  logic [15:0] dutyDiff;
  logic [15:0] steppedDuty;
  logic        holdExpired;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    startClamped  = (cfgStartDuty  > cfgPeriod) ? cfgPeriod : cfgStartDuty;
    targetClamped = (cfgTargetDuty > cfgPeriod) ? cfgPeriod : cfgTargetDuty;
    dutyDiff      = (effTarget >= curDuty) ? (effTarget - curDuty) : (curDuty - effTarget);
    steppedDuty   = effTarget;
    if (stepReg != 16'd0 && dutyDiff > stepReg) begin
      // Both operands are clamped to the period, so the remaining distance bounds the step.
      steppedDuty = (effTarget > curDuty) ? (curDuty + stepReg) : (curDuty - stepReg);
    end
    holdExpired   = (holdCnt + 8'd1) == effHold;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge refClock) begin
    if (!resetN) begin
      state          <= IDLE;
      curDuty        <= 16'd0;
      periodReg      <= 16'd0;
      effTarget      <= 16'd0;
      stepReg        <= 16'd0;
      effHold        <= 8'd1;
      holdCnt        <= 8'd0;
      loadCnt        <= 2'd0;
      stopPending    <= 1'b0;
      pwmEnDC        <= 1'b0;
      pwmWritePeriod <= 1'b0;
      pwmData        <= 16'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmdStart && !cmdStop) begin
            periodReg      <= cfgPeriod;
            effTarget      <= targetClamped;
            stepReg        <= cfgStep;
            effHold        <= (cfgHold == 8'd0) ? 8'd1 : cfgHold;
            curDuty        <= startClamped;
            loadCnt        <= 2'd0;
            stopPending    <= 1'b0;
            pwmEnDC        <= 1'b1;
            pwmWritePeriod <= 1'b1;
            pwmData        <= cfgPeriod;
            busy           <= 1'b1;
            state          <= LOAD;
          end
        end
        LOAD: begin
          if (loadCnt == 2'd2) begin
            pwmEnDC        <= 1'b0;
            pwmWritePeriod <= 1'b0;
            pwmData        <= curDuty;
            if (stopPending || cmdStop) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= GAP;
            end
          end else begin
            // A stop here is remembered so the period write always completes.
            loadCnt     <= loadCnt + 2'd1;
            stopPending <= stopPending | cmdStop;
          end
        end
        GAP: begin
          if (cmdStop) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (curDuty == effTarget) begin
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            holdCnt <= 8'd0;
            state   <= RAMP;
          end
        end
        RAMP: begin
          if (cmdStop) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (pwmEvent) begin
            if (holdExpired) begin
              holdCnt <= 8'd0;
              curDuty <= steppedDuty;
              pwmData <= steppedDuty;
              if (steppedDuty == effTarget) begin
                done  <= 1'b1;
                state <= FINISH;
              end
            end else begin
              holdCnt <= holdCnt + 8'd1;
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed ramps, stop/reset/collision
// scenarios and randomized configurations against a closed-form duty model.
module tb_pwm_ramp_ctrl;

  logic        refClock = 1'b0;
  logic        resetN = 1'b0;
  logic        cmdStart = 1'b0;
  logic        cmdStop = 1'b0;
  logic [15:0] cfgPeriod = 16'd0;
  logic [15:0] cfgStartDuty = 16'd0;
  logic [15:0] cfgTargetDuty = 16'd0;
  logic [15:0] cfgStep = 16'd0;
  logic [7:0]  cfgHold = 8'd0;
  logic        pwmEvent = 1'b0;
  logic        pwmEnDC;
  logic        pwmWritePeriod;
  logic [15:0] pwmData;
  logic        busy;
  logic        done;

  int testsRun = 0;
  int testsFailed = 0;

  pwm_ramp_ctrl dut (
    .refClock       (refClock),
    .resetN         (resetN),
    .cmdStart       (cmdStart),
    .cmdStop        (cmdStop),
    .cfgPeriod      (cfgPeriod),
    .cfgStartDuty   (cfgStartDuty),
    .cfgTargetDuty  (cfgTargetDuty),
    .cfgStep        (cfgStep),
    .cfgHold        (cfgHold),
    .pwmEvent       (pwmEvent),
    .pwmEnDC        (pwmEnDC),
    .pwmWritePeriod (pwmWritePeriod),
    .pwmData        (pwmData),
    .busy           (busy),
    .done           (done)
  );

  always #5 refClock = ~refClock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge refClock);
    #1;
  endtask

  // Runs one sequence. abortKind: 0 none, 1 cmdStop on event abortEvt, 2 reset on event abortEvt.
  task automatic run_sequence(input logic [15:0] period, input logic [15:0] start,
                              input logic [15:0] target, input logic [15:0] step,
                              input logic [7:0] hold, input int abortEvt, input int abortKind,
                              input bit collide, input string tag);
    logic [15:0] seq[$];
    int s, t, v, eh, lastEvt, k;
    logic [15:0] held;
    bit up;
    // Duty after k steps, closed form: start moved k*step toward target, saturated at target.
    s  = (start  > period) ? int'(period) : int'(start);
    t  = (target > period) ? int'(period) : int'(target);
    up = (t >= s);
    k  = 0;
    v  = s;
    seq.push_back(16'(v));
    while (v != t) begin
      k++;
      if (step == 16'd0) v = t;
      else begin
        v = up ? s + k * int'(step) : s - k * int'(step);
        if (up ? (v >= t) : (v <= t)) v = t;
      end
      seq.push_back(16'(v));
    end
    eh      = (hold == 8'd0) ? 1 : int'(hold);
    lastEvt = (seq.size() - 1) * eh;

    cfgPeriod = period; cfgStartDuty = start; cfgTargetDuty = target;
    cfgStep = step; cfgHold = hold; cmdStart = 1'b1;
    tick();
    cmdStart = 1'b0;
    cfgPeriod = 16'($urandom); cfgStartDuty = 16'($urandom);
    cfgTargetDuty = 16'($urandom); cfgStep = 16'($urandom); cfgHold = 8'($urandom);

    for (int i = 0; i < 3; i++) begin
      testsRun++;
      if (pwmWritePeriod !== 1'b1 || pwmEnDC !== 1'b1 || pwmData !== period || busy !== 1'b1) begin
        testsFailed++;
        $display("FAIL %s load%0d: wp=%b en=%b data=%0d busy=%b, expected wp=1 en=1 data=%0d busy=1",
                 tag, i, pwmWritePeriod, pwmEnDC, pwmData, busy, period);
      end
      tick();
    end

    testsRun++;
    if (pwmWritePeriod !== 1'b0 || pwmEnDC !== 1'b0 || pwmData !== seq[0] || busy !== 1'b1 || done !== 1'b0) begin
      testsFailed++;
      $display("FAIL %s gap: wp=%b en=%b data=%0d busy=%b done=%b, expected 0 0 %0d 1 0",
               tag, pwmWritePeriod, pwmEnDC, pwmData, busy, done, seq[0]);
    end
    tick();

    if (seq.size() == 1) begin
      testsRun++;
      if (done !== 1'b1 || busy !== 1'b1) begin
        testsFailed++;
        $display("FAIL %s jump_done: done=%b busy=%b, expected done=1 busy=1", tag, done, busy);
      end
      tick();
      testsRun++;
      if (done !== 1'b0 || busy !== 1'b0 || pwmData !== 16'(t)) begin
        testsFailed++;
        $display("FAIL %s jump_idle: done=%b busy=%b data=%0d, expected 0 0 %0d", tag, done, busy, pwmData, t);
      end
      return;
    end

    for (int e = 1; e <= lastEvt; e++) begin
      repeat ($urandom_range(0, 3)) tick();
      pwmEvent = 1'b1;
      if (collide && e == 1) begin
        cmdStart = 1'b1; cfgPeriod = 16'd60000; cfgTargetDuty = 16'd0; cfgStep = 16'd1;
      end
      if (e == abortEvt && abortKind == 1) cmdStop = 1'b1;
      if (e == abortEvt && abortKind == 2) resetN = 1'b0;
      tick();
      pwmEvent = 1'b0; cmdStart = 1'b0; cmdStop = 1'b0; resetN = 1'b1;

      if (e == abortEvt && abortKind == 1) begin
        held = seq[(e - 1) / eh];
        testsRun++;
        if (busy !== 1'b0 || done !== 1'b0 || pwmData !== held) begin
          testsFailed++;
          $display("FAIL %s stop: busy=%b done=%b data=%0d, expected 0 0 %0d", tag, busy, done, pwmData, held);
        end
        repeat (3) begin
          pwmEvent = 1'b1; tick(); pwmEvent = 1'b0; tick();
        end
        testsRun++;
        if (busy !== 1'b0 || done !== 1'b0 || pwmData !== held) begin
          testsFailed++;
          $display("FAIL %s stop_hold: busy=%b done=%b data=%0d, expected 0 0 %0d", tag, busy, done, pwmData, held);
        end
        return;
      end
      if (e == abortEvt && abortKind == 2) begin
        testsRun++;
        if (busy !== 1'b0 || done !== 1'b0 || pwmData !== 16'd0 || pwmEnDC !== 1'b0 || pwmWritePeriod !== 1'b0) begin
          testsFailed++;
          $display("FAIL %s reset_mid: busy=%b done=%b data=%0d en=%b wp=%b, expected all 0",
                   tag, busy, done, pwmData, pwmEnDC, pwmWritePeriod);
        end
        return;
      end

      testsRun++;
      if (pwmData !== seq[e / eh] || done !== (e == lastEvt) || busy !== 1'b1) begin
        testsFailed++;
        $display("FAIL %s event%0d: data=%0d done=%b busy=%b, expected data=%0d done=%b busy=1",
                 tag, e, pwmData, done, busy, seq[e / eh], (e == lastEvt));
      end
    end

    tick();
    testsRun++;
    if (done !== 1'b0 || busy !== 1'b0 || pwmData !== 16'(t) || pwmEnDC !== 1'b0) begin
      testsFailed++;
      $display("FAIL %s end: done=%b busy=%b data=%0d en=%b, expected 0 0 %0d 0", tag, done, busy, pwmData, pwmEnDC, t);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (2) tick();
    testsRun++;
    if (busy !== 1'b0 || done !== 1'b0 || pwmData !== 16'd0 || pwmEnDC !== 1'b0 || pwmWritePeriod !== 1'b0) begin
      testsFailed++;
      $display("FAIL reset: busy=%b done=%b data=%0d en=%b wp=%b, expected all 0",
               busy, done, pwmData, pwmEnDC, pwmWritePeriod);
    end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_up_ramp();
    run_sequence(16'd124, 16'd0, 16'd100, 16'd10, 8'd2, 0, 0, 1'b0, "up_ramp");
  endtask

  task automatic test_down_ramp();
    run_sequence(16'd124, 16'd100, 16'd5, 16'd20, 8'd1, 0, 0, 1'b0, "down_ramp");
  endtask

  task automatic test_clamp_jump();
    run_sequence(16'd124, 16'd200, 16'd300, 16'd0, 8'd3, 0, 0, 1'b0, "clamp_jump");
  endtask

  task automatic test_stop_ramp();
    run_sequence(16'd124, 16'd0, 16'd100, 16'd10, 8'd2, 3, 1, 1'b0, "stop_ramp");
  endtask

  task automatic test_stop_load();
    cfgPeriod = 16'd124; cfgStartDuty = 16'd30; cfgTargetDuty = 16'd100;
    cfgStep = 16'd10; cfgHold = 8'd1; cmdStart = 1'b1;
    tick();
    cmdStart = 1'b0;
    cmdStop = 1'b1;
    tick();
    cmdStop = 1'b0;
    for (int i = 1; i < 3; i++) begin
      testsRun++;
      if (pwmWritePeriod !== 1'b1 || pwmEnDC !== 1'b1 || busy !== 1'b1) begin
        testsFailed++;
        $display("FAIL stop_load load%0d: wp=%b en=%b busy=%b, expected 1 1 1", i, pwmWritePeriod, pwmEnDC, busy);
      end
      tick();
    end
    testsRun++;
    if (busy !== 1'b0 || pwmWritePeriod !== 1'b0 || pwmEnDC !== 1'b0 || pwmData !== 16'd30 || done !== 1'b0) begin
      testsFailed++;
      $display("FAIL stop_load idle: busy=%b wp=%b en=%b data=%0d done=%b, expected 0 0 0 30 0",
               busy, pwmWritePeriod, pwmEnDC, pwmData, done);
    end
    repeat (2) begin
      pwmEvent = 1'b1; tick(); pwmEvent = 1'b0; tick();
    end
    testsRun++;
    if (busy !== 1'b0 || pwmData !== 16'd30) begin
      testsFailed++;
      $display("FAIL stop_load hold: busy=%b data=%0d, expected 0 30", busy, pwmData);
    end
  endtask

  task automatic test_collisions();
    run_sequence(16'd124, 16'd0, 16'd100, 16'd10, 8'd1, 0, 0, 1'b1, "start_while_busy");
    cfgPeriod = 16'd124; cfgStartDuty = 16'd77; cfgTargetDuty = 16'd20;
    cmdStart = 1'b1; cmdStop = 1'b1;
    tick();
    cmdStart = 1'b0; cmdStop = 1'b0;
    repeat (2) begin
      testsRun++;
      if (busy !== 1'b0 || pwmWritePeriod !== 1'b0 || pwmData !== 16'd100) begin
        testsFailed++;
        $display("FAIL start_stop_same: busy=%b wp=%b data=%0d, expected 0 0 100", busy, pwmWritePeriod, pwmData);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_ramp();
    run_sequence(16'd124, 16'd0, 16'd100, 16'd10, 8'd2, 7, 2, 1'b0, "reset_mid");
    run_sequence(16'd124, 16'd10, 16'd60, 16'd25, 8'd2, 0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [15:0] p, s, t, st;
    logic [7:0]  h;
    for (int r = 0; r < 8; r++) begin
      p  = 16'($urandom_range(1, 300));
      s  = 16'($urandom_range(0, 400));
      t  = 16'($urandom_range(0, 400));
      st = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      h  = 8'($urandom_range(0, 3));
      run_sequence(p, s, t, st, h, 0, 0, 1'b0, $sformatf("random%0d", r));
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_up_ramp();
    test_down_ramp();
    test_clamp_jump();
    test_stop_ramp();
    test_stop_load();
    test_collisions();
    test_reset_mid_ramp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
